apb_sleep_ctrl_mc: RTL and testbench

Multi-core APB sleep controller for the PULPino peripheral subsystem, sitting on the APB bus next to the event unit and driving one fetch-enable and one clock-gate line per core. It generalises single-core sleep control to `N_CORES` independent per-core state machines. Each core has a maskable interrupt wake-up, a programmable wake-up settle delay, and APB error signalling. Optional per-core sleep-cycle counters support power profiling.

---
 rtl/apb_sleep_ctrl_mc_if.sv | 23 ++
 rtl/apb_sleep_ctrl_mc.sv | 154 +++++++++++++++
 tb/tb_apb_sleep_ctrl_mc.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_sleep_ctrl_mc_if.sv
// APB slave bus bundle for apb_sleep_ctrl_mc; the master drives the request, the slave returns data and status.
interface apb_sleep_ctrl_mc_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_sleep_ctrl_mc.sv
// Multi-core APB sleep controller: one RUN/SHUTDOWN/SLEEP/WAKE FSM per core behind an APB register file.
// Define SLEEP_CNT_EN to build the per-core 32-bit sleep-cycle counters at word index 0x04+c.
module apb_sleep_ctrl_mc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_CORES        = 2
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  apb_sleep_ctrl_mc_if.slave apb,
  input  logic [N_CORES-1:0] irq_i,
  input  logic [N_CORES-1:0] event_i,
  input  logic [N_CORES-1:0] core_busy_i,
  output logic [N_CORES-1:0] fetch_en_o,
  output logic [N_CORES-1:0] clk_gate_core_o
);
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SHUTDOWN = 2'd1;
  localparam logic [1:0] ST_SLEEP    = 2'd2;
  localparam logic [1:0] ST_WAKE     = 2'd3;

  localparam logic [5:0] IDX_CTRL   = 6'h00;
  localparam logic [5:0] IDX_STATUS = 6'h01;
  localparam logic [5:0] IDX_MASK   = 6'h02;
  localparam logic [5:0] IDX_DLY    = 6'h03;
  localparam logic [5:0] IDX_CNT    = 6'h04;
`ifdef SLEEP_CNT_EN
  localparam logic [5:0] IDX_END    = 6'(4 + N_CORES);
`else
  localparam logic [5:0] IDX_END    = IDX_CNT;
`endif

  logic [N_CORES-1:0] ctrl_reg, ctrl_next;
  logic [N_CORES-1:0] status_reg;
  logic [N_CORES-1:0] wake_mask_reg;
  logic [N_CORES-1:0] in_sleep;
  logic [7:0]         wake_dly_reg;
  logic [5:0]         idx;
  logic               access, err, wr_ok, rd_ok;
  logic [31:0]        rdata;
  logic               unused_bits;

  assign idx    = apb.PADDR[7:2];
  assign access = apb.PSEL & apb.PENABLE;
  // Unmapped indices and writes to the read-only STATUS are rejected without side effects.
  assign err    = access & ((idx >= IDX_END) | (apb.PWRITE & (idx == IDX_STATUS)));
  assign wr_ok  = access & apb.PWRITE & ~err;
  assign rd_ok  = access & ~apb.PWRITE & ~err;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;
  assign apb.PRDATA  = rd_ok ? rdata : 32'h0;
  assign unused_bits = ^{apb.PADDR[APB_ADDR_WIDTH-1:0], apb.PWDATA};

`ifdef SLEEP_CNT_EN
  logic [31:0] sleep_cnt_reg [N_CORES];

  always_ff @(posedge HCLK) begin
    for (int c = 0; c < N_CORES; c++) begin
      if (!HRESETn)
        sleep_cnt_reg[c] <= '0;
      else if (wr_ok && idx == IDX_CNT + 6'(c))
        sleep_cnt_reg[c] <= '0;
      else if (in_sleep[c] && sleep_cnt_reg[c] != '1)
        sleep_cnt_reg[c] <= sleep_cnt_reg[c] + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata = 32'h0;
    case (idx)
      IDX_CTRL:   rdata[N_CORES-1:0] = ctrl_reg;
      IDX_STATUS: rdata[N_CORES-1:0] = status_reg;
      IDX_MASK:   rdata[N_CORES-1:0] = wake_mask_reg;
      IDX_DLY:    rdata[7:0]         = wake_dly_reg;
      default:    ;
    endcase
`ifdef SLEEP_CNT_EN
    for (int c = 0; c < N_CORES; c++)
      if (idx == IDX_CNT + 6'(c)) rdata = sleep_cnt_reg[c];
`endif
  end

  // A sleep request is consumed once the core sleeps or an event arrives; a same-cycle write wins.
  always_comb begin
    ctrl_next = ctrl_reg & ~(in_sleep | event_i);
    if (wr_ok && idx == IDX_CTRL) ctrl_next = apb.PWDATA[N_CORES-1:0];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_reg      <= '0;
      status_reg    <= '0;
      wake_mask_reg <= '1;
      wake_dly_reg  <= 8'd4;
    end else begin
      ctrl_reg   <= ctrl_next;
      status_reg <= in_sleep;
      if (wr_ok && idx == IDX_MASK) wake_mask_reg <= apb.PWDATA[N_CORES-1:0];
      if (wr_ok && idx == IDX_DLY)  wake_dly_reg  <= apb.PWDATA[7:0];
    end
  end

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
    logic [1:0] state_reg, state_next;
    logic [1:0] target_reg, target_next;
    logic [7:0] dly_reg, dly_next;
    logic       wake_irq;

    assign wake_irq = irq_i[gi] & wake_mask_reg[gi];

    always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      dly_next    = dly_reg;
      case (state_reg)
        ST_RUN:
          if (ctrl_reg[gi] && !event_i[gi]) state_next = ST_SHUTDOWN;
        ST_SHUTDOWN:
          if (event_i[gi])                          state_next = ST_RUN;
          else if (!core_busy_i[gi] && !wake_irq)   state_next = ST_SLEEP;
        ST_SLEEP:
          if (event_i[gi] || wake_irq) begin
            state_next  = ST_WAKE;
            target_next = event_i[gi] ? ST_RUN : ST_SHUTDOWN;
            dly_next    = wake_dly_reg;
          end
        ST_WAKE: begin
          // An event seen while settling always lands the core back in RUN.
          if (event_i[gi]) target_next = ST_RUN;
          if (dly_reg == 8'd0) state_next = event_i[gi] ? ST_RUN : target_reg;
          else                 dly_next   = dly_reg - 8'd1;
        end
        default: state_next = ST_RUN;
      endcase
    end

    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        state_reg  <= ST_RUN;
        target_reg <= ST_RUN;
        dly_reg    <= 8'd0;
      end else begin
        state_reg  <= state_next;
        target_reg <= target_next;
        dly_reg    <= dly_next;
      end
    end

    assign in_sleep[gi]        = (state_reg == ST_SLEEP);
    assign clk_gate_core_o[gi] = (state_reg != ST_SLEEP);
    assign fetch_en_o[gi]      = (state_reg == ST_RUN) & ~(ctrl_reg[gi] & ~event_i[gi]);
  end
endmodule

// File: tb/tb_apb_sleep_ctrl_mc.sv
// Directed bench for apb_sleep_ctrl_mc: register vector table plus hand-timed sleep/wake sequences.
module tb_apb_sleep_ctrl_mc;
  localparam int N = 2;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] irq_i = '0;
  logic [N-1:0] event_i = '0;
  logic [N-1:0] core_busy_i = '0;
  logic [N-1:0] fetch_en_o;
  logic [N-1:0] clk_gate_core_o;
  int           total = 0;
  int           bad = 0;

  apb_sleep_ctrl_mc_if #(.APB_ADDR_WIDTH(12)) apb_if ();

  apb_sleep_ctrl_mc #(.APB_ADDR_WIDTH(12), .N_CORES(N)) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .apb             (apb_if),
    .irq_i           (irq_i),
    .event_i         (event_i),
    .core_busy_i     (core_busy_i),
    .fetch_en_o      (fetch_en_o),
    .clk_gate_core_o (clk_gate_core_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // Returns #1 after the edge that closes the access phase.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge HCLK);
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = wr;
    apb_if.PADDR   = addr;
    apb_if.PWDATA  = wdata;
    @(negedge HCLK);
    apb_if.PENABLE = 1'b1;
    #1;
    rdata = apb_if.PRDATA;
    err   = apb_if.PSLVERR;
    @(posedge HCLK);
    #1;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    apb_xfer(1'b1, addr, wdata, rd, er);
  endtask

  task automatic apb_rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    apb_xfer(1'b0, addr, 32'h0, rd, er);
    chk(name, rd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;

    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    apb_if.PADDR = '0;  apb_if.PWDATA = '0;

    vecs.push_back('{1'b0, 12'h000, 32'h0,        32'h0,  1'b0}); // CTRL reset
    vecs.push_back('{1'b0, 12'h004, 32'h0,        32'h0,  1'b0}); // STATUS reset
    vecs.push_back('{1'b0, 12'h008, 32'h0,        32'h3,  1'b0}); // WAKE_MASK reset
    vecs.push_back('{1'b0, 12'h00C, 32'h0,        32'h4,  1'b0}); // WAKE_DLY reset
    vecs.push_back('{1'b1, 12'h00C, 32'h1FF,      32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h00C, 32'h0,        32'hFF, 1'b0}); // truncated to 8 bits
    vecs.push_back('{1'b1, 12'h008, 32'hFFFFFFFF, 32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h008, 32'h0,        32'h3,  1'b0}); // bits >= N_CORES read 0
    vecs.push_back('{1'b1, 12'h004, 32'hFF,       32'h0,  1'b1}); // write to STATUS
    vecs.push_back('{1'b0, 12'h004, 32'h0,        32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h000, 32'h0,        32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h0FC, 32'h0,        32'h0,  1'b1}); // index 0x3F
    vecs.push_back('{1'b0, 12'hFFC, 32'h0,        32'h0,  1'b1});
    vecs.push_back('{1'b1, 12'h0FC, 32'h12,       32'h0,  1'b1});
    vecs.push_back('{1'b1, 12'h00C, 32'h4,        32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h10C, 32'h0,        32'h4,  1'b0}); // high address bits ignored
`ifdef SLEEP_CNT_EN
    vecs.push_back('{1'b0, 12'h010, 32'h0,        32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h014, 32'h0,        32'h0,  1'b0});
    vecs.push_back('{1'b0, 12'h018, 32'h0,        32'h0,  1'b1}); // past last counter
`else
    vecs.push_back('{1'b0, 12'h010, 32'h0,        32'h0,  1'b1});
    vecs.push_back('{1'b1, 12'h014, 32'h1,        32'h0,  1'b1});
`endif

    tick(3);
    HRESETn = 1'b1;
    chk("reset_fetch_en", 32'(fetch_en_o), 32'h3);
    chk("reset_clk_gate", 32'(clk_gate_core_o), 32'h3);
    chk("reset_pslverr", 32'(apb_if.PSLVERR), 32'h0);
    chk("pready", 32'(apb_if.PREADY), 32'h1);

    foreach (vecs[i]) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Minimum sleep entry on core0, then event wake with WAKE_DLY=4.
    apb_wr(12'h000, 32'h1);
    chk("entry_T_fetch", 32'(fetch_en_o), 32'h2);
    chk("entry_T_clk", 32'(clk_gate_core_o), 32'h3);
    tick();
    chk("entry_T1_clk", 32'(clk_gate_core_o), 32'h3);
    tick();
    chk("entry_T2_clk", 32'(clk_gate_core_o), 32'h2);
    chk("entry_T2_fetch", 32'(fetch_en_o), 32'h2);
    tick(3);
    apb_rd_chk("sleep_status", 12'h004, 32'h1);
    apb_rd_chk("sleep_ctrl_cleared", 12'h000, 32'h0);
    event_i[0] = 1'b1;
    tick();
    event_i[0] = 1'b0;
    chk("wake_S1_clk", 32'(clk_gate_core_o), 32'h3);
    chk("wake_S1_fetch", 32'(fetch_en_o), 32'h2);
    tick(4);
    chk("wake_S5_fetch", 32'(fetch_en_o), 32'h2);
    tick();
    chk("wake_S6_fetch", 32'(fetch_en_o), 32'h3);
    apb_rd_chk("wake_ctrl", 12'h000, 32'h0);

    // Masked irq must not wake; unmasking wakes into SHUTDOWN.
    apb_wr(12'h000, 32'h1);
    tick(2);
    chk("irq_asleep", 32'(clk_gate_core_o), 32'h2);
    apb_wr(12'h008, 32'h0);
    irq_i[0] = 1'b1;
    tick(6);
    chk("irq_masked_asleep", 32'(clk_gate_core_o), 32'h2);
    apb_wr(12'h008, 32'h1);
    chk("irq_unmask_E", 32'(clk_gate_core_o), 32'h2);
    tick();
    chk("irq_wake_clk", 32'(clk_gate_core_o), 32'h3);
    tick(9);
    chk("irq_shutdown_clk", 32'(clk_gate_core_o), 32'h3);
    chk("irq_shutdown_fetch", 32'(fetch_en_o), 32'h2);
    core_busy_i[0] = 1'b1;
    irq_i[0] = 1'b0;
    tick(3);
    chk("busy_holds_shutdown", 32'(clk_gate_core_o), 32'h3);
    core_busy_i[0] = 1'b0;
    tick();
    chk("idle_resleep", 32'(clk_gate_core_o), 32'h2);

    // WAKE_DLY=0: fetch back exactly two cycles after the event.
    apb_wr(12'h00C, 32'h0);
    event_i[0] = 1'b1;
    tick();
    event_i[0] = 1'b0;
    chk("dly0_S1_fetch", 32'(fetch_en_o), 32'h2);
    chk("dly0_S1_clk", 32'(clk_gate_core_o), 32'h3);
    tick();
    chk("dly0_S2_fetch", 32'(fetch_en_o), 32'h3);

    // Both cores asleep and woken in the same cycle.
    apb_wr(12'h000, 32'h3);
    tick(2);
    chk("both_asleep", 32'(clk_gate_core_o), 32'h0);
    event_i = 2'b11;
    tick();
    event_i = 2'b00;
    chk("both_wake_clk", 32'(clk_gate_core_o), 32'h3);
    tick();
    chk("both_run_fetch", 32'(fetch_en_o), 32'h3);

`ifdef SLEEP_CNT_EN
    apb_wr(12'h000, 32'h2);
    tick(2);
    chk("cnt_core1_asleep", 32'(clk_gate_core_o), 32'h1);
    tick(99);
    event_i[1] = 1'b1;
    tick();
    event_i[1] = 1'b0;
    apb_rd_chk("sleep_cnt1", 12'h014, 32'd100);
    apb_wr(12'h014, 32'hDEAD);
    apb_rd_chk("sleep_cnt1_cleared", 12'h014, 32'h0);
`endif

    // Reset asserted while asleep returns the core to RUN and restores registers.
    apb_wr(12'h008, 32'h2);
    apb_wr(12'h00C, 32'h7);
    apb_wr(12'h000, 32'h1);
    tick(2);
    chk("pre_reset_asleep", 32'(clk_gate_core_o), 32'h2);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    chk("midsleep_reset_fetch", 32'(fetch_en_o), 32'h3);
    chk("midsleep_reset_clk", 32'(clk_gate_core_o), 32'h3);
    apb_rd_chk("post_reset_ctrl", 12'h000, 32'h0);
    apb_rd_chk("post_reset_status", 12'h004, 32'h0);
    apb_rd_chk("post_reset_mask", 12'h008, 32'h3);
    apb_rd_chk("post_reset_dly", 12'h00C, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
